stream_video_tpg: RTL and testbench
===================================

STREAM_VIDEO_TPG -- requirements
Module: stream_video_tpg

Interface
REQ-001 Parameters SHALL be, one per line:
  - IMG_WIDTH, 200, active pixels per line (2..65535).
  - IMG_HEIGHT, 200, lines per frame (2..65535).
  - FRAME_GAP, 16, idle cycles with tvalid low between frames (0 allowed).
REQ-002 Ports SHALL be, one per line:
  - clk  in  1  single clock; one clock, all logic on its rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - enable  in  1  run request.
  - pattern_sel  in  2  pattern select: 0 solid, 1 ramp, 2 colour bars, 3 checkerboard.
  - solid_color  in  24  pixel value for pattern 0.
  - m_axis_video_tdata  out  24  video data.
  - m_axis_video_tvalid  out  1  valid.
  - m_axis_video_tready  in  1  ready.
  - m_axis_video_tuser  out  1  start of frame.
  - m_axis_video_tlast  out  1  end of line.
  - frame_cnt  out  16  frames completed, wraps 0xFFFF->0.
  - busy  out  1  high whenever state is not IDLE.

Function
REQ-003 All m_axis outputs, frame_cnt and busy SHALL be driven directly from registers.
REQ-004 The state machine SHALL have three states:
  - IDLE -> ACTIVE when enable=1.
  - ACTIVE -> GAP on handshake of the last pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1).
  - GAP -> ACTIVE when the gap counter reaches FRAME_GAP and enable=1.
  - GAP -> IDLE when the gap counter reaches FRAME_GAP and enable=0.
REQ-005 A handshake SHALL be a cycle with tvalid=1 and tready=1.
REQ-006 x SHALL advance only on a handshake, wrap to 0 after IMG_WIDTH-1, and increment y on wrap; y SHALL wrap to 0 after IMG_HEIGHT-1.
REQ-007 Once tvalid=1, tvalid, tdata, tuser and tlast SHALL hold stable until the handshake.
REQ-008 tvalid SHALL rise on the clock edge after the one on which IDLE (or the end of GAP) samples enable=1, with the pixel at (0,0) presented.
REQ-009 tuser SHALL be 1 only for pixel (0,0); tlast SHALL be 1 only for x=IMG_WIDTH-1.
REQ-010 pattern_sel and solid_color SHALL be latched on entry to ACTIVE and held for the whole frame.
REQ-011 Pixel generation for the latched pattern SHALL be:
  - Pattern 0: the latched solid_color.
  - Pattern 1: {x[7:0], x[7:0], x[7:0]}.
  - Pattern 3: (x[3]^y[3]) ? FFFFFF : 000000.
REQ-012 Pattern 2 SHALL use bar width BW = IMG_WIDTH/8 (integer, minimum 1).
  - Bar index SHALL increment every BW pixels, saturate at 7, and reset each line.
  - Bar colours 0..7 SHALL be FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Bar tracking SHALL use a counter, not a divider.
REQ-013 enable dropping mid-frame SHALL NOT truncate the frame; the frame completes, then GAP, then IDLE.
REQ-014 frame_cnt SHALL increment on the last-pixel handshake.
REQ-015 In GAP, tvalid SHALL be 0 for exactly FRAME_GAP cycles; FRAME_GAP=0 SHALL give back-to-back frames, with the next (0,0) presented on the cycle after the last handshake.
REQ-016 tready=0 held indefinitely SHALL stall all counters without data change.

Reset
REQ-017 On reset=0, asynchronously, the block SHALL set:
  - state=IDLE.
  - x=y=0, gap counter=0.
  - tvalid=tuser=tlast=0, tdata=0.
  - frame_cnt=0, busy=0.
REQ-018 Reset asserted mid-frame SHALL drop tvalid immediately, without completing the frame.
REQ-019 After deassertion, the first frame SHALL restart at (0,0) with tuser=1.

Structure
REQ-020 Package stream_video_pkg SHALL hold:
  - the pattern_sel encodings.
  - the state encoding.
  - the 8-entry bar colour table.
REQ-021 Pixel colour generation SHALL reside in one combinational sub-module, stream_video_pattern_lut (inputs: pattern, x, y, bar index, solid colour; output: 24-bit pixel).

Verification
REQ-022 Directed scenarios:
  - IMG 8x4, FRAME_GAP=2, pattern 1, tready=1: 32 beats; tdata 000000,010101..070707 per line; tuser on beat 0 only; tlast on beats 7,15,23,31; then 2 tvalid-low cycles; frame_cnt=1.
  - Random tready (50%) on the same frame: captured stream identical to the previous scenario; tdata/tuser/tlast never change while tvalid=1 and tready=0.
  - IMG 16x2, pattern 2: beats 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000, repeated on line 1.
  - enable dropped at beat 5 of an 8x4 frame: all 32 beats delivered, GAP, then IDLE with busy=0.
  - reset pulsed low at beat 10: tvalid=0 in the same cycle; after release and enable=1, tuser=1 with tdata of pixel (0,0); frame_cnt=0.
  - FRAME_GAP=0 with enable held: tuser of frame 2 on the cycle after tlast of the last line of frame 1; frame_cnt counts 1, 2.

Source files
------------

// File: rtl/stream_video_tpg_pkg.sv
// -----------------------------------------------------------------------------
// stream_video_pkg
// Shared definitions for the streaming video test-pattern generator:
//   - pattern_e   : pattern_sel encodings
//   - state_e     : generator state machine encoding
//   - pixel_t     : 24-bit pixel word
//   - BAR_COLORS  : 8-entry colour-bar table, index 0 is the leftmost bar
//   - bar_width() : width of one colour bar for a given line length
// -----------------------------------------------------------------------------
package stream_video_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_BARS    = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Packed array: the leftmost literal is element 7, the rightmost element 0.
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000,  // 7
    24'h0000FF,  // 6
    24'hFF0000,  // 5
    24'hFF00FF,  // 4
    24'h00FF00,  // 3
    24'h00FFFF,  // 2
    24'hFFFF00,  // 1
    24'hFFFFFF   // 0
  };

  // One eighth of the line, but never narrower than a single pixel.
  function automatic int bar_width(input int img_width);
    return (img_width / 8 < 1) ? 1 : img_width / 8;
  endfunction

endpackage

// File: rtl/stream_video_tpg_if.sv
// -----------------------------------------------------------------------------
// stream_video_tpg_if
// AXI4-Stream video channel (24-bit pixels).
//   tdata  : pixel value
//   tvalid : beat valid
//   tready : sink ready
//   tuser  : start of frame (pixel 0,0)
//   tlast  : end of line
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface stream_video_tpg_if;
  import stream_video_pkg::*;

  pixel_t tdata;
  logic   tvalid;
  logic   tready;
  logic   tuser;
  logic   tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/stream_video_pattern_lut.sv
// -----------------------------------------------------------------------------
// stream_video_pattern_lut
// Purely combinational pixel colour generator.
//   pattern     : latched pattern selection
//   x           : low byte of the pixel column (the only column bits any
//                 pattern looks at)
//   y3          : bit 3 of the line index (the only row bit any pattern uses)
//   bar_idx     : current colour-bar index, already saturated at 7
//   solid_color : latched solid colour
//   pixel       : resulting 24-bit pixel
// -----------------------------------------------------------------------------
module stream_video_pattern_lut
  import stream_video_pkg::*;
(
  input  pattern_e   pattern,
  input  logic [7:0] x,
  input  logic       y3,
  input  logic [2:0] bar_idx,
  input  pixel_t     solid_color,
  output pixel_t     pixel
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    pixel = 24'h000000;
    case (pattern)
      PAT_SOLID:   pixel = solid_color;
      PAT_RAMP:    pixel = {x, x, x};
      PAT_BARS:    pixel = BAR_COLORS[bar_idx];
      PAT_CHECKER: pixel = (x[3] ^ y3) ? 24'hFFFFFF : 24'h000000;
      default:     pixel = 24'h000000;
    endcase
  end

endmodule

// File: rtl/stream_video_tpg.sv
// -----------------------------------------------------------------------------
// stream_video_tpg
// AXI4-Stream video test-pattern generator: IMG_WIDTH x IMG_HEIGHT frames
// separated by FRAME_GAP idle cycles while enable stays high.
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low
//   enable       : run request, sampled only at frame boundaries
//   pattern_sel  : 0 solid, 1 ramp, 2 colour bars, 3 checkerboard
//   solid_color  : pixel value for the solid pattern
//   m_axis_video : AXI4-Stream video master (tuser = SOF, tlast = EOL)
//   frame_cnt    : completed frames, wraps at 16 bits
//   busy         : high whenever the generator is not idle
// All stream outputs, frame_cnt and busy come straight from flops. The pixel
// for the next beat is computed one step ahead from the next coordinates, so
// a new beat can be presented on every handshake with no bubble.
// -----------------------------------------------------------------------------
module stream_video_tpg
  import stream_video_pkg::*;
#(
  parameter int IMG_WIDTH  = 200,
  parameter int IMG_HEIGHT = 200,
  parameter int FRAME_GAP  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                pattern_sel,
  input  pixel_t                    solid_color,
  stream_video_tpg_if.master        m_axis_video,
  output logic [15:0]               frame_cnt,
  output logic                      busy
);

  localparam int               BAR_W    = bar_width(IMG_WIDTH);
  localparam logic [15:0]      X_LAST   = 16'(IMG_WIDTH - 1);
  localparam logic [15:0]      Y_LAST   = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0]      BAR_LAST = 16'(BAR_W - 1);
  localparam int               GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  state_e           state, state_nxt;
  logic [15:0]      x, y, bar_cnt;
  logic [2:0]       bar_idx;
  logic [GAP_W-1:0] gap_cnt;
  pattern_e         pat_q;
  pixel_t           solid_q;

  pixel_t           tdata_q;
  logic             tvalid_q, tuser_q, tlast_q;

  logic             handshake, last_pixel, frame_done, advance, gap_done, start_frame;
  logic [15:0]      x_nxt, y_nxt, bar_cnt_nxt;
  logic [2:0]       bar_idx_nxt;
  pattern_e         pat_nxt;
  pixel_t           solid_nxt, pixel_nxt;

  assign handshake  = tvalid_q & m_axis_video.tready;
  assign last_pixel = (x == X_LAST) && (y == Y_LAST);
  assign frame_done = handshake && last_pixel;
  assign advance    = handshake && !last_pixel;
  // The counter is compared one short of FRAME_GAP so the transition edge
  // itself is the FRAME_GAP-th idle cycle's end.
  assign gap_done   = (state == ST_GAP) && (gap_cnt == GAP_LAST);

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt   = ST_ACTIVE;
          start_frame = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (frame_done) begin
          if (FRAME_GAP == 0) begin
            // No gap: either chain straight into the next frame or stop.
            if (enable) start_frame = 1'b1;
            else        state_nxt   = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          if (enable) begin
            state_nxt   = ST_ACTIVE;
            start_frame = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next coordinates and bar tracking (counter-based, no divider)
  // ---------------------------------------------------------------------------
  always_comb begin
    x_nxt       = x + 16'd1;
    y_nxt       = y;
    bar_cnt_nxt = bar_cnt + 16'd1;
    bar_idx_nxt = bar_idx;
    if (bar_cnt == BAR_LAST) begin
      bar_cnt_nxt = 16'd0;
      if (bar_idx != 3'd7) bar_idx_nxt = bar_idx + 3'd1;
    end
    if (x == X_LAST) begin
      x_nxt       = 16'd0;
      y_nxt       = (y == Y_LAST) ? 16'd0 : y + 16'd1;
      bar_cnt_nxt = 16'd0;
      bar_idx_nxt = 3'd0;
    end
    if (start_frame) begin
      x_nxt       = 16'd0;
      y_nxt       = 16'd0;
      bar_cnt_nxt = 16'd0;
      bar_idx_nxt = 3'd0;
    end
  end

  // The first pixel of a frame must already use the settings being latched.
  assign pat_nxt   = start_frame ? pattern_e'(pattern_sel) : pat_q;
  assign solid_nxt = start_frame ? solid_color : solid_q;

  stream_video_pattern_lut u_lut (
    .pattern     (pat_nxt),
    .x           (x_nxt[7:0]),
    .y3          (y_nxt[3]),
    .bar_idx     (bar_idx_nxt),
    .solid_color (solid_nxt),
    .pixel       (pixel_nxt)
  );

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x         <= 16'd0;
      y         <= 16'd0;
      bar_cnt   <= 16'd0;
      bar_idx   <= 3'd0;
      gap_cnt   <= '0;
      pat_q     <= PAT_SOLID;
      solid_q   <= 24'h000000;
      tdata_q   <= 24'h000000;
      tvalid_q  <= 1'b0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      frame_cnt <= 16'd0;
      busy      <= 1'b0;
    end else begin
      if (start_frame || advance) begin
        x        <= x_nxt;
        y        <= y_nxt;
        bar_cnt  <= bar_cnt_nxt;
        bar_idx  <= bar_idx_nxt;
        tdata_q  <= pixel_nxt;
        tvalid_q <= 1'b1;
        tuser_q  <= start_frame;
        tlast_q  <= (x_nxt == X_LAST);
      end else if (frame_done) begin
        x        <= 16'd0;
        y        <= 16'd0;
        bar_cnt  <= 16'd0;
        bar_idx  <= 3'd0;
        tvalid_q <= 1'b0;
        tuser_q  <= 1'b0;
        tlast_q  <= 1'b0;
      end

      if (start_frame) begin
        pat_q   <= pat_nxt;
        solid_q <= solid_nxt;
      end

      if (frame_done) frame_cnt <= frame_cnt + 16'd1;

      if (state == ST_GAP && !gap_done) gap_cnt <= gap_cnt + 1'b1;
      else                              gap_cnt <= '0;

      busy <= (state_nxt != ST_IDLE);
    end
  end

  assign m_axis_video.tdata  = tdata_q;
  assign m_axis_video.tvalid = tvalid_q;
  assign m_axis_video.tuser  = tuser_q;
  assign m_axis_video.tlast  = tlast_q;

endmodule

// File: tb/tb_stream_video_tpg.sv
// -----------------------------------------------------------------------------
// tb_stream_video_tpg
// Two generator instances: A is 8x4 with a 2-cycle gap, B is 16x2 with no
// gap. Every beat is compared against a reference model that derives the
// pixel from the frame position with plain arithmetic. Outputs are sampled on
// the falling edge; inputs change right after that sample.
// -----------------------------------------------------------------------------
module tb_stream_video_tpg;
  import stream_video_pkg::*;

  localparam int AW = 8, AH = 4, AGAP = 2;
  localparam int BWID = 16, BH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_a, en_b, rdy, use_b;
  logic [1:0]  sel;
  logic [23:0] solid;
  logic [15:0] fc_a, fc_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  stream_video_tpg_if vif_a ();
  stream_video_tpg_if vif_b ();
  assign vif_a.tready = rdy;
  assign vif_b.tready = rdy;

  stream_video_tpg #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .FRAME_GAP(AGAP)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .enable       (en_a),
    .pattern_sel  (sel),
    .solid_color  (solid),
    .m_axis_video (vif_a),
    .frame_cnt    (fc_a),
    .busy         (busy_a)
  );

  stream_video_tpg #(.IMG_WIDTH(BWID), .IMG_HEIGHT(BH), .FRAME_GAP(0)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .enable       (en_b),
    .pattern_sel  (sel),
    .solid_color  (solid),
    .m_axis_video (vif_b),
    .frame_cnt    (fc_b),
    .busy         (busy_b)
  );

  // Observed instance
  logic [23:0] m_data;
  logic        m_valid, m_user, m_last, m_busy;
  logic [15:0] m_fc;
  always_comb begin
    if (use_b) begin
      m_data = vif_b.tdata;  m_valid = vif_b.tvalid; m_user = vif_b.tuser;
      m_last = vif_b.tlast;  m_busy  = busy_b;       m_fc   = fc_b;
    end else begin
      m_data = vif_a.tdata;  m_valid = vif_a.tvalid; m_user = vif_a.tuser;
      m_last = vif_a.tlast;  m_busy  = busy_a;       m_fc   = fc_a;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] ref_pixel(input int pat, input logic [23:0] sc,
                                            input int x, input int y, input int w);
    int bw, b;
    logic [7:0] xb;
    case (pat)
      0: return sc;
      1: begin
        xb = 8'(x % 256);
        return {xb, xb, xb};
      end
      2: begin
        bw = (w / 8 < 1) ? 1 : w / 8;
        b  = x / bw;
        if (b > 7) b = 7;
        return bar_tab[b];
      end
      default: return ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Consume one frame from the observed instance. Stops early after stop_at
  // beats (>= 0). On a full frame, returns at the falling edge after the last
  // handshake with tready low. Inputs are scrambled mid-frame and restored on
  // the last beat to prove they are latched only at frame start.
  task automatic run_frame(input int w, input int h, input int pat, input logic [23:0] sc,
                           input bit rand_rdy, input int drop_at, input int stop_at);
    int n = 0;
    int cyc = 0;
    int total = w * h;
    int lim = (stop_at >= 0) ? stop_at : total;
    bit pv = 1'b0;
    logic [26:0] prev = '0;
    logic [26:0] cur;
    while (n < lim && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      cur = {m_valid, m_data, m_user, m_last};
      if (pv) check("hold while stalled", 32'(cur), 32'(prev));
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && rdy) begin
        check($sformatf("beat %0d", n), 32'(cur),
              32'({1'b1, ref_pixel(pat, sc, n % w, n / w, w), n == 0, (n % w) == w - 1}));
        if (n == drop_at) begin
          if (use_b) en_b = 1'b0;
          else       en_a = 1'b0;
        end
        if (n == 3) begin
          sel   = 2'($urandom);
          solid = 24'($urandom);
        end
        if (n == total - 1) begin
          sel   = 2'(pat);
          solid = sc;
        end
        n++;
      end
      pv   = m_valid && !rdy;
      prev = cur;
    end
    if (n < lim) check("frame timeout", 32'(n), 32'(lim));
    if (stop_at < 0) begin
      @(negedge clk);
      rdy = 1'b0;
    end
  endtask

  // Count tvalid-low cycles starting at the current falling edge.
  task automatic count_gap(output int lows);
    lows = 0;
    rdy  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid) break;
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic start_check(input string tag, input logic [23:0] exp_pix);
    @(negedge clk);
    check({tag, " first beat"}, 32'({m_valid, m_user, m_data}), 32'({2'b11, exp_pix}));
    check({tag, " busy"}, 32'(m_busy), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int lows;
    logic [23:0] sc;

    reset = 1'b0; en_a = 1'b0; en_b = 1'b0; rdy = 1'b0; use_b = 1'b0;
    sel = 2'd0; solid = 24'h0;

    repeat (3) @(negedge clk);
    check("reset tvalid", 32'(m_valid), 32'd0);
    check("reset tuser/tlast", 32'({m_user, m_last}), 32'd0);
    check("reset tdata", 32'(m_data), 32'd0);
    check("reset frame_cnt", 32'(m_fc), 32'd0);
    check("reset busy", 32'(m_busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle tvalid", 32'(m_valid), 32'd0);

    // Ramp frame, tready high, enable held: gap length and next frame start
    sc = 24'($urandom);
    sel = 2'd1; solid = sc; en_a = 1'b1;
    start_check("ramp", 24'h000000);
    run_frame(AW, AH, 1, sc, 1'b0, -1, -1);
    count_gap(lows);
    check("gap length A", 32'(lows), 32'(AGAP));
    check("frame_cnt after frame 1", 32'(m_fc), 32'd1);
    check("frame 2 sof", 32'({m_valid, m_user, m_data}), 32'({2'b11, 24'h000000}));

    // Same frame under random tready, enable dropped at beat 5
    run_frame(AW, AH, 1, sc, 1'b1, 5, -1);
    check("post-drop tvalid", 32'(m_valid), 32'd0);
    check("post-drop busy in gap", 32'(m_busy), 32'd1);
    check("frame_cnt after frame 2", 32'(m_fc), 32'd2);
    repeat (AGAP + 2) @(negedge clk);
    check("idle after gap busy", 32'(m_busy), 32'd0);
    check("idle after gap tvalid", 32'(m_valid), 32'd0);

    // Every pattern from idle with random colour, random tready, random drop
    for (int p = 0; p < 4; p++) begin
      sc = 24'($urandom);
      sel = 2'(p); solid = sc; en_a = 1'b1;
      start_check($sformatf("pattern %0d", p), ref_pixel(p, sc, 0, 0, AW));
      run_frame(AW, AH, p, sc, 1'b1, $urandom_range(0, AW * AH - 1), -1);
      repeat (AGAP + 2) @(negedge clk);
      check($sformatf("pattern %0d idle", p), 32'({m_busy, m_valid}), 32'd0);
    end
    check("frame_cnt after 6 frames", 32'(m_fc), 32'd6);

    // Reset in the middle of a frame
    sc = 24'($urandom);
    sel = 2'd3; solid = sc; en_a = 1'b1;
    start_check("checker", 24'h000000);
    run_frame(AW, AH, 3, sc, 1'b0, -1, 10);
    #1 reset = 1'b0;
    rdy = 1'b0;
    #1;
    check("async reset tvalid", 32'(m_valid), 32'd0);
    check("async reset frame_cnt", 32'(m_fc), 32'd0);
    sc = 24'($urandom);
    sel = 2'd0; solid = sc;
    @(negedge clk);
    reset = 1'b1;
    start_check("after reset", sc);
    run_frame(AW, AH, 0, sc, 1'b1, 0, -1);
    check("frame_cnt after reset frame", 32'(m_fc), 32'd1);

    // B: colour bars, no gap, enable held then dropped in frame 2
    use_b = 1'b1;
    sc = 24'($urandom);
    sel = 2'd2; solid = sc; en_b = 1'b1;
    start_check("bars", 24'hFFFFFF);
    run_frame(BWID, BH, 2, sc, 1'b0, -1, -1);
    check("back-to-back sof", 32'({m_valid, m_user, m_data}), 32'({2'b11, 24'hFFFFFF}));
    check("B frame_cnt 1", 32'(m_fc), 32'd1);
    run_frame(BWID, BH, 2, sc, 1'b1, 20, -1);
    check("B frame_cnt 2", 32'(m_fc), 32'd2);
    check("B idle", 32'({m_busy, m_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
